// File: rtl/vending_machine_gen.sv
`default_nettype none
// ============================================================================
// Module   : vending_machine_gen
// Brief    : Parametrised vending controller. Credits coins, dispenses one
//            selected drink per transaction from a per-slot stock, then pays
//            change one coin per cycle using greedy 50/10/5/1 denominations.
//            Supports cancel/refund, sold-out flags and restocking.
// Revision : 1.0 - initial release
// ============================================================================
module vending_machine_gen #(
    parameter int                          MONEY_W    = 8,
    parameter int                          N_DRINK    = 4,
    parameter int                          SEL_W      = 3,
    parameter logic [N_DRINK*MONEY_W-1:0]  PRICE_LIST = {8'd25, 8'd20, 8'd15, 8'd10},
    parameter int                          STOCK_W    = 4,
    parameter int                          STOCK_INIT = 5,
    parameter int                          MAX_CREDIT = 200
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MONEY_W-1:0] coin,
    input  logic [SEL_W-1:0]   drink_choose,
    input  logic               cancel,
    input  logic               restock,
    input  logic [SEL_W-1:0]   restock_sel,
    output logic [2:0]         state,
    output logic [MONEY_W-1:0] total_money,
    output logic [SEL_W-1:0]   drink_out,
    output logic               drink_valid,
    output logic [MONEY_W-1:0] change_coin,
    output logic               change_valid,
    output logic               coin_reject,
    output logic [N_DRINK-1:0] sold_out
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_CREDIT = 3'd1;
    localparam logic [2:0] c_VEND   = 3'd2;
    localparam logic [2:0] c_CHANGE = 3'd3;

    localparam logic [MONEY_W-1:0] c_D1  = MONEY_W'(1);
    localparam logic [MONEY_W-1:0] c_D5  = MONEY_W'(5);
    localparam logic [MONEY_W-1:0] c_D10 = MONEY_W'(10);
    localparam logic [MONEY_W-1:0] c_D50 = MONEY_W'(50);
    localparam logic [MONEY_W:0]   c_MAX = (MONEY_W+1)'(MAX_CREDIT);
    localparam logic [STOCK_W-1:0] c_STOCK_INIT = STOCK_W'(STOCK_INIT);

    logic [2:0]                      r_state;
    logic [2:0]                      w_state_nxt;
    logic [MONEY_W-1:0]              r_total;
    logic [MONEY_W-1:0]              w_total_nxt;
    logic [MONEY_W-1:0]              r_last_coin;
    logic [N_DRINK-1:0][STOCK_W-1:0] r_stock;
    logic [N_DRINK-1:0][STOCK_W-1:0] w_stock_nxt;
    logic [SEL_W-1:0]                r_drink_out;
    logic [SEL_W-1:0]                w_drink_out_nxt;
    logic                            r_drink_valid;
    logic                            w_drink_valid_nxt;
    logic [MONEY_W-1:0]              r_change_coin;
    logic [MONEY_W-1:0]              w_change_coin_nxt;
    logic                            r_change_valid;
    logic                            w_change_valid_nxt;
    logic                            r_coin_reject;
    logic                            w_coin_reject_nxt;

    logic                            w_coin_edge;
    logic                            w_coin_ok;
    logic [MONEY_W:0]                w_sum;
    logic                            w_coin_accept;
    logic [MONEY_W-1:0]              w_price;
    logic                            w_sel_in_range;
    logic                            w_sel_stock_ok;
    logic                            w_sel_valid;
    logic [MONEY_W-1:0]              w_change_d;

    // One credit event per insertion: only the 0 -> nonzero transition counts,
    // and the add is one bit wider so the credit limit check cannot wrap.
    assign w_coin_edge   = (coin != '0) && (r_last_coin == '0);
    assign w_coin_ok     = (coin == c_D1) || (coin == c_D5) || (coin == c_D10) || (coin == c_D50);
    assign w_sum         = {1'b0, r_total} + {1'b0, coin};
    assign w_coin_accept = w_coin_edge && w_coin_ok && (w_sum <= c_MAX) &&
                           ((r_state == c_IDLE) || (r_state == c_CREDIT));

    // Look up price and stock availability of the requested slot
    always_comb begin
        w_price        = '0;
        w_sel_in_range = 1'b0;
        w_sel_stock_ok = 1'b0;
        for (int k = 0; k < N_DRINK; k++) begin
            if (drink_choose == SEL_W'(k + 1)) begin
                w_sel_in_range = 1'b1;
                w_price        = PRICE_LIST[k*MONEY_W +: MONEY_W];
                w_sel_stock_ok = (r_stock[k] != '0);
            end
        end
    end

    assign w_sel_valid = w_sel_in_range && w_sel_stock_ok && (r_total >= w_price);

    // Greedy change denomination: largest coin not exceeding remaining credit
    always_comb begin
        if (r_total >= c_D50) begin
            w_change_d = c_D50;
        end else if (r_total >= c_D10) begin
            w_change_d = c_D10;
        end else if (r_total >= c_D5) begin
            w_change_d = c_D5;
        end else begin
            w_change_d = c_D1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; in CREDIT a coin edge outranks cancel, which outranks selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_coin_accept) begin
                    w_state_nxt = c_CREDIT;
                end
            end
            c_CREDIT: begin
                if (!w_coin_edge) begin
                    if (cancel) begin
                        w_state_nxt = c_CHANGE;
                    end else if (w_sel_valid) begin
                        w_state_nxt = c_VEND;
                    end
                end
            end
            c_VEND: begin
                w_state_nxt = (r_total != '0) ? c_CHANGE : c_IDLE;
            end
            c_CHANGE: begin
                // Leave on the same edge that pays out the last coin
                if ((r_total == '0) || (r_total == w_change_d)) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Datapath and pulse outputs for the coming cycle
    always_comb begin
        w_total_nxt        = r_total;
        w_stock_nxt        = r_stock;
        w_drink_out_nxt    = '0;
        w_drink_valid_nxt  = 1'b0;
        w_change_coin_nxt  = '0;
        w_change_valid_nxt = 1'b0;
        w_coin_reject_nxt  = w_coin_edge && !w_coin_accept;
        case (r_state)
            c_IDLE: begin
                if (w_coin_accept) begin
                    w_total_nxt = w_sum[MONEY_W-1:0];
                end
                if (restock) begin
                    for (int k = 0; k < N_DRINK; k++) begin
                        if (restock_sel == SEL_W'(k + 1)) begin
                            w_stock_nxt[k] = '1;
                        end
                    end
                end
            end
            c_CREDIT: begin
                if (w_coin_accept) begin
                    w_total_nxt = w_sum[MONEY_W-1:0];
                end else if (!w_coin_edge && !cancel && w_sel_valid) begin
                    w_drink_out_nxt   = drink_choose;
                    w_drink_valid_nxt = 1'b1;
                    w_total_nxt       = r_total - w_price;
                    for (int k = 0; k < N_DRINK; k++) begin
                        if (drink_choose == SEL_W'(k + 1)) begin
                            w_stock_nxt[k] = r_stock[k] - STOCK_W'(1);
                        end
                    end
                end
            end
            c_CHANGE: begin
                if (r_total != '0) begin
                    w_change_coin_nxt  = w_change_d;
                    w_change_valid_nxt = 1'b1;
                    w_total_nxt        = r_total - w_change_d;
                end
            end
            default: ;
        endcase
    end

    // Datapath, stock and output registers; reset discards any pending credit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_total        <= '0;
            r_last_coin    <= '0;
            r_stock        <= {N_DRINK{c_STOCK_INIT}};
            r_drink_out    <= '0;
            r_drink_valid  <= 1'b0;
            r_change_coin  <= '0;
            r_change_valid <= 1'b0;
            r_coin_reject  <= 1'b0;
        end else begin
            r_total        <= w_total_nxt;
            r_last_coin    <= coin;
            r_stock        <= w_stock_nxt;
            r_drink_out    <= w_drink_out_nxt;
            r_drink_valid  <= w_drink_valid_nxt;
            r_change_coin  <= w_change_coin_nxt;
            r_change_valid <= w_change_valid_nxt;
            r_coin_reject  <= w_coin_reject_nxt;
        end
    end

    generate
        for (genvar k = 0; k < N_DRINK; k++) begin : g_sold_out
            assign sold_out[k] = (r_stock[k] == '0);
        end
    endgenerate

    assign state        = r_state;
    assign total_money  = r_total;
    assign drink_out    = r_drink_out;
    assign drink_valid  = r_drink_valid;
    assign change_coin  = r_change_coin;
    assign change_valid = r_change_valid;
    assign coin_reject  = r_coin_reject;

endmodule
`default_nettype wire

// File: doc/vending_machine_gen.md
Name: vending_machine_gen

Overview:
- Parametrised, next-generation vending controller.
- Accepts coins and tracks credit across a configurable number of drinks, each with its own price and a stock counter.
- Dispenses one selected drink, then returns change one coin per cycle using greedy 50/10/5/1 denominations.
- Supports cancel/refund, sold-out flags and restocking; sits between the coin acceptor/keypad front end and the dispenser/change hopper actuators.

Parameters:
- MONEY_W, 8, width of coin, credit and change datapaths.
- N_DRINK, 4, number of drink slots, selectable as codes 1..N_DRINK.
- SEL_W, 3, selection code width; must satisfy 2**SEL_W > N_DRINK.
- PRICE_LIST, {8'd25,8'd20,8'd15,8'd10}, packed N_DRINK*MONEY_W; slot k (code k+1) price is bits [k*MONEY_W +: MONEY_W].
- STOCK_W, 4, per-slot stock counter width.
- STOCK_INIT, 5, stock loaded into every slot at reset.
- MAX_CREDIT, 200, highest credit value allowed; must be ≤ 2**MONEY_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- coin  in  MONEY_W  coin value, held nonzero while a coin is present; 0 = none.
- drink_choose  in  SEL_W  selection code; 0 = none.
- cancel  in  1  refund request, level-sampled.
- restock  in  1  restock strobe.
- restock_sel  in  SEL_W  slot code to restock.
- state  out  3  0=IDLE, 1=CREDIT, 2=VEND, 3=CHANGE.
- total_money  out  MONEY_W  current credit.
- drink_out  out  SEL_W  dispensed slot code; valid only with drink_valid.
- drink_valid  out  1  one-cycle dispense pulse.
- change_coin  out  MONEY_W  denomination being returned; valid only with change_valid.
- change_valid  out  1  one-cycle pulse per returned coin.
- coin_reject  out  1  one-cycle pulse: a coin edge was not credited.
- sold_out  out  N_DRINK  bit k = slot k stock is 0 (combinational from the stock registers).

Behaviour:
- Reset, asynchronous:
  - state=IDLE, total_money=0, last_coin=0, every stock=STOCK_INIT.
  - drink_out, drink_valid, change_coin, change_valid and coin_reject all 0.
- Coin edge detection:
  - Register last_coin each cycle.
  - coin_edge = (coin!=0) && (last_coin==0); exactly one event per insertion, however long the coin is held.
- Coin acceptance on coin_edge:
  - Credited only when state ∈ {IDLE, CREDIT}, coin ∈ {1,5,10,50}, and total_money+coin ≤ MAX_CREDIT.
  - Add is computed at MONEY_W+1 bits so it cannot wrap.
  - Any other coin_edge → coin_reject=1 next cycle, credit unchanged.
- Pulse outputs (drink_valid, change_valid, coin_reject) default to 0 every cycle.
- IDLE:
  - An accepted coin → total_money=coin, go to CREDIT.
  - Selection and cancel are ignored.
- CREDIT, priority coin_edge > cancel > selection:
  - Accepted coin: credit += coin, stay in CREDIT; selection in the same cycle is ignored.
  - cancel=1 with no coin edge → CHANGE.
  - Selection s is valid when 1≤s≤N_DRINK, stock[s-1]>0 and total_money ≥ price(s). A valid selection, registered at the next edge:
    - drink_out=s, drink_valid=1
    - stock[s-1] -= 1
    - total_money -= price(s)
    - state → VEND
  - Invalid selection (out of range, sold out, insufficient credit): no action, stay in CREDIT.
- VEND: lasts exactly one cycle; next state is CHANGE if total_money>0, else IDLE.
- CHANGE, one coin per cycle while total_money>0:
  - d = largest of {50,10,5,1} ≤ total_money; change_coin=d, change_valid=1, total_money -= d.
  - When the coin that zeroes the credit is emitted, state → IDLE on that same edge.
  - Entering CHANGE with credit 0 (cancel at zero is unreachable, but defined): go straight to IDLE with no pulse.
- Restock: when state=IDLE and restock=1 with restock_sel in 1..N_DRINK, stock[restock_sel-1] saturates to 2**STOCK_W-1. Ignored in any other state or for an out-of-range code.
- Latency:
  - Coin edge → credit updated 1 cycle later.
  - Valid selection → drink_valid 1 cycle later.
  - First change coin appears 1 cycle after entering CHANGE.
- Reset mid-vend or mid-change aborts immediately; pending credit and change are lost, and stock is restored to STOCK_INIT.

Test Plan:
- Insert 50, then 1, 1 (each coin dropped to 0 between insertions); select 2 (coke, 15) → drink_out=2 pulse, total 37; change pulses 10,10,10,5,1,1 on consecutive cycles; then IDLE with total 0.
- Hold coin=10 for 5 cycles → credited once, total 10; insert 3 → coin_reject pulse, total stays 10.
- Credit 10, select 4 (milk, 25) → no dispense, stay in CREDIT; assert cancel → single change pulse of 10, then IDLE.
- Vend slot 1 five times from reset (credit 10 each) → sold_out[0]=1 and a sixth select 1 is ignored; restock slot 1 in IDLE → sold_out[0]=0, stock 15.
- Credit 190, insert 50 → coin_reject, total 190; coin edge in the same cycle as a valid selection → coin credited, no dispense.
- Assert reset during CHANGE with 27 remaining → all outputs 0 immediately, state IDLE, stock back to 5.
